// File: rtl/cp0_except_ctrl.sv
// cp0_except_ctrl: owns the CP0 registers (Status, Cause, EPC, BadVAddr,
// Count, Compare) and sequences exception entry and ERET. On entry or ERET
// the block raises flush_o for FLUSH_CYCLES cycles. newpc_o carries the
// redirect target during that time, and new events are blocked until the
// flush drains.
// Optional feature macro: CP0_TIMER_EN (Count/Compare timer interrupt).
// Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
module cp0_except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] STATUS_RST   = 32'h0040FF00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  input  logic [5:0]  ext_int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        dbg_state_o
);

  localparam logic       S_IDLE  = 1'b0;
  localparam logic       S_FLUSH = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // Status bits software may change: IM[15:8], EXL[1], IE[0].
  localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;

  logic        r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_newpc;
  logic [31:0] r_status;
  logic        r_cause_bd;
  logic [5:0]  r_ext_ip;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_idle;
  logic        w_take;
  logic        w_eret;
  logic        w_exc;
  logic        w_wr;
  logic        w_exl;
  logic        w_badaddr_exc;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic        w_ip7;
  logic [31:0] w_cause;

  // Events and MTC0 writes are only accepted while not draining a flush.
  assign w_idle        = (r_state == S_IDLE);
  assign w_take        = w_idle && (excepttype_i != 32'h0);
  assign w_eret        = w_take && (excepttype_i == 32'hE);
  assign w_exc         = w_take && !w_eret;
  assign w_wr          = w_idle && we_i;
  assign w_exl         = r_status[1];
  assign w_badaddr_exc = (excepttype_i == 32'h4) || (excepttype_i == 32'h5);

  // FSM: IDLE -> FLUSH on any event, count down, return to IDLE; latch redirect target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_newpc <= 32'h0;
    end else if (r_state == S_IDLE) begin
      if (w_take) begin
        r_state <= S_FLUSH;
        r_cnt   <= CNT_INIT;
        r_newpc <= w_eret ? r_epc : EXC_VECTOR;
      end
    end else begin
      if (r_cnt == 4'd0) r_state <= S_IDLE;
      else               r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Status: MTC0 commits masked bits; exception/ERET then overrides EXL.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status <= STATUS_RST;
    end else begin
      if (w_wr && (waddr_i == REG_STATUS))
        r_status <= (r_status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
      if (w_exc)       r_status[1] <= 1'b1;
      else if (w_eret) r_status[1] <= 1'b0;
    end
  end

  // Cause: hardware IP sampled every cycle, software IP by MTC0, BD/ExcCode on entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause_bd <= 1'b0;
      r_ext_ip   <= 6'h0;
      r_ip_sw    <= 2'h0;
      r_exc_code <= 5'h0;
    end else begin
      r_ext_ip <= ext_int_i;
      if (w_wr && (waddr_i == REG_CAUSE)) r_ip_sw <= wdata_i[9:8];
      if (w_exc) begin
        r_exc_code <= (excepttype_i == 32'h1) ? 5'h0 : excepttype_i[4:0];
        if (!w_exl) r_cause_bd <= in_delayslot_i;
      end
    end
  end

  // EPC and BadVAddr: MTC0 to EPC, overridden by a first-level exception entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_epc      <= 32'h0;
      r_badvaddr <= 32'h0;
    end else begin
      if (w_wr && (waddr_i == REG_EPC)) r_epc <= wdata_i;
      if (w_exc && !w_exl) r_epc <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
      if (w_exc && w_badaddr_exc) r_badvaddr <= bad_addr_i;
    end
  end

`ifdef CP0_TIMER_EN
  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  // Timer: Count advances every second clock; a match latches TI until Compare is rewritten.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick    <= 1'b0;
      r_count   <= 32'h0;
      r_compare <= 32'h0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (w_wr && (waddr_i == REG_COUNT)) r_count <= wdata_i;
      else if (r_tick)                    r_count <= r_count + 32'd1;
      if (w_wr && (waddr_i == REG_COMPARE)) begin
        r_compare <= wdata_i;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_count   = r_count;
  assign w_compare = r_compare;
  assign w_ti      = r_ti;
  assign w_ip7     = r_ext_ip[5] | r_ti;
`else
  assign w_count   = 32'h0;
  assign w_compare = 32'h0;
  assign w_ti      = 1'b0;
  assign w_ip7     = r_ext_ip[5];
`endif

  assign w_cause = {r_cause_bd, w_ti, 14'h0, w_ip7, r_ext_ip[4:0], r_ip_sw,
                    1'b0, r_exc_code, 2'b00};

  // MFC0 read mux: registered values only, so a same-cycle write is not visible.
  always_comb begin
    rdata_o = 32'h0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = r_badvaddr;
      REG_COUNT:    rdata_o = w_count;
      REG_COMPARE:  rdata_o = w_compare;
      REG_STATUS:   rdata_o = r_status;
      REG_CAUSE:    rdata_o = w_cause;
      REG_EPC:      rdata_o = r_epc;
      default:      rdata_o = 32'h0;
    endcase
  end

  assign status_o    = r_status;
  assign cause_o     = w_cause;
  assign epc_o       = r_epc;
  assign flush_o     = (r_state == S_FLUSH);
  assign newpc_o     = r_newpc;
  assign dbg_state_o = r_state;

endmodule
